polirv_mem_responder: RTL and testbench
=======================================

POLIRV_MEM_RESPONDER -- requirements
Module: polirv_mem_responder

Interface
REQ-001 SHALL provide parameter i_addr_bits, default 6, width of the instruction byte address.
REQ-002 SHALL provide parameter d_addr_bits, default 6, width of the data byte address.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk and rst_n; rst_n asserted low clears state immediately, independent of clk.
REQ-004 SHALL have clk  input  1  rising-edge clock.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have i_mem_addr  input  i_addr_bits  instruction byte address from the core.
REQ-007 SHALL have i_mem_data  output  32  instruction word to the core.
REQ-008 SHALL have d_mem_we  input  1  core data write enable.
REQ-009 SHALL have d_mem_addr  input  d_addr_bits  data byte address from the core.
REQ-010 SHALL have d_mem_data  inout  64  bidirectional data bus shared with the core.
REQ-011 SHALL have ld_start  input  1  single-cycle request to reload the program.
REQ-012 SHALL have ld_valid  input  1  load byte valid.
REQ-013 SHALL have ld_byte  input  8  load byte.
REQ-014 SHALL have ld_last  input  1  marks the final byte of the program, qualified by ld_valid.
REQ-015 SHALL have ld_ready  output  1  block accepts a load byte this cycle.
REQ-016 SHALL have core_rst_n  output  1  active-low reset held on the core until the program is loaded.

Function
REQ-017 SHALL hold instruction memory of 2^(i_addr_bits-2) x 32 bits, indexed by i_mem_addr[i_addr_bits-1:2]; i_mem_addr[1:0] are ignored.
REQ-018 SHALL hold data memory of 2^(d_addr_bits-3) x 64 bits, indexed by d_mem_addr[d_addr_bits-1:3]; d_mem_addr[2:0] are ignored.
REQ-019 SHALL drive i_mem_data combinationally from the addressed instruction word in every state (zero-latency read).
REQ-020 SHALL drive d_mem_data with the addressed data word, combinationally, only when state is RUN and d_mem_we=0; otherwise d_mem_data is high-impedance.
REQ-021 SHALL, in RUN with d_mem_we=1, write d_mem_data into the addressed data word on the rising clk edge; the write is visible to a read of that address in the next cycle.
REQ-022 SHALL implement FSM states CLEAR, LOAD, RUN.
REQ-023 CLEAR: write zero to data word n at each cycle, n counting from 0; after the last index (2^(d_addr_bits-3)-1), go to LOAD on the next edge.
REQ-024 LOAD: ld_ready=1; each cycle with ld_valid=1 accepts ld_byte; bytes assemble little-endian (first byte -> bits 7:0) into a 32-bit word.
REQ-025 SHALL write the assembled word to instruction word w on the edge accepting its 4th byte, then increment w and clear the byte count.
REQ-026 SHALL, on an accepted byte with ld_last=1, write the current word (unreceived bytes zero) to word w and go to RUN on that edge.
REQ-027 SHALL, when word w = 2^(i_addr_bits-2)-1 completes without ld_last, go to RUN on that edge; no further bytes are accepted.
REQ-028 RUN: ld_ready=0, ld_valid and ld_byte ignored; core_rst_n=1 starting the cycle after entering RUN, registered.
REQ-029 SHALL set core_rst_n=0 in CLEAR and LOAD.
REQ-030 SHALL, on ld_start=1 in RUN, go to CLEAR on the next edge, core_rst_n dropping to 0 on that edge; ld_start in CLEAR or LOAD is ignored.
REQ-031 SHALL ignore d_mem_we in CLEAR and LOAD; core writes are suppressed.
REQ-032 SHALL not clear instruction memory on reset or reload; unloaded words keep prior contents.

Reset
REQ-033 SHALL, on rst_n=0, immediately set state CLEAR, clear counters and the partial word, drive core_rst_n=0, ld_ready=0, d_mem_data high-impedance.
REQ-034 SHALL, on rst_n=0 during LOAD, discard the partial word; completed instruction words remain written.
REQ-035 SHALL begin CLEAR on the first clk edge after rst_n deasserts.

Verification
REQ-036 Reset release -> core_rst_n=0 for 8 CLEAR cycles plus LOAD; all 8 data words read 0 once in RUN.
REQ-037 Load bytes 13,00,10,00 then 93,00,20,00 with ld_last on the last -> instruction words 0x00100013, 0x00200093; core_rst_n=1 one cycle after RUN entry.
REQ-038 Load 5 bytes 01,02,03,04,05 with ld_last on 05 -> word0=0x04030201, word1=0x00000005.
REQ-039 RUN: d_mem_we=1, addr 0x08, bus 0xDEADBEEF_CAFEF00D, then d_mem_we=0, addr 0x0F -> block drives 0xDEADBEEF_CAFEF00D; with d_mem_we=1 block drives Z.
REQ-040 Stream 64 bytes without ld_last -> 16 words written, RUN entered on 64th byte, 65th ld_valid not accepted (ld_ready=0).
REQ-041 Assert rst_n=0 after 2 bytes in LOAD, release, reload -> partial bytes absent; ld_start in RUN re-zeroes data memory and holds core_rst_n=0.

Source files
------------

// File: rtl/polirv_mem_responder.sv
// Memory responder for a small RISC-V core: holds instruction and data
// memory, zeroes data memory and streams a program into instruction memory
// byte by byte, then releases the core from reset and serves its accesses.
module polirv_mem_responder #(
    parameter int i_addr_bits = 6,
    parameter int d_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [31:0]            i_mem_data,
    input  logic                   d_mem_we,
    input  logic [d_addr_bits-1:0] d_mem_addr,
    inout  wire  [63:0]            d_mem_data,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_byte,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   core_rst_n
);

    localparam int I_IDX   = i_addr_bits - 2;
    localparam int D_IDX   = d_addr_bits - 3;
    localparam int I_WORDS = 2 ** I_IDX;
    localparam int D_WORDS = 2 ** D_IDX;

    localparam logic [I_IDX-1:0] I_LAST = {I_IDX{1'b1}};
    localparam logic [D_IDX-1:0] D_LAST = {D_IDX{1'b1}};
    localparam logic [I_IDX-1:0] I_ONE  = {{(I_IDX-1){1'b0}}, 1'b1};
    localparam logic [D_IDX-1:0] D_ONE  = {{(D_IDX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic [31:0] imem_r [I_WORDS];
    logic [63:0] dmem_r [D_WORDS];

    state_t           state_r;
    logic [D_IDX-1:0] clr_idx_r;
    logic [I_IDX-1:0] word_idx_r;
    logic [1:0]       byte_cnt_r;
    logic [23:0]      partial_r;
    logic             ld_ready_r;
    logic             core_rst_n_r;

    state_t           state_s;
    logic [D_IDX-1:0] clr_idx_s;
    logic [I_IDX-1:0] word_idx_s;
    logic [1:0]       byte_cnt_s;
    logic [23:0]      partial_s;
    logic [31:0]      assembled_s;
    logic             imem_we_s;
    logic [31:0]      imem_wdata_s;
    logic             dmem_we_s;
    logic [D_IDX-1:0] dmem_widx_s;
    logic [63:0]      dmem_wdata_s;
    logic             dmem_drive_s;
    logic             unused_addr_bits_s;

    // Byte-offset address bits are ignored; keep them visibly consumed.
    assign unused_addr_bits_s = ^{i_mem_addr[1:0], d_mem_addr[2:0]};

    // Zero-latency reads: instruction port always, data port only while the core owns the bus.
    assign i_mem_data   = imem_r[i_mem_addr[i_addr_bits-1:2]];
    assign dmem_drive_s = (state_r == ST_RUN) && !d_mem_we;
    assign d_mem_data   = dmem_drive_s ? dmem_r[d_mem_addr[d_addr_bits-1:3]] : {64{1'bz}};

    assign ld_ready   = ld_ready_r;
    assign core_rst_n = core_rst_n_r;

    // Next-state, loader word assembly and memory write selection.
    always_comb begin
        state_s      = state_r;
        clr_idx_s    = clr_idx_r;
        word_idx_s   = word_idx_r;
        byte_cnt_s   = byte_cnt_r;
        partial_s    = partial_r;
        imem_we_s    = 1'b0;
        imem_wdata_s = 32'd0;
        dmem_we_s    = 1'b0;
        dmem_widx_s  = {D_IDX{1'b0}};
        dmem_wdata_s = 64'd0;
        // New byte lands in its little-endian lane; lanes not yet received stay zero.
        assembled_s  = {8'd0, partial_r} | ({24'd0, ld_byte} << {byte_cnt_r, 3'b000});

        case (state_r)
            ST_CLEAR: begin
                dmem_we_s    = 1'b1;
                dmem_widx_s  = clr_idx_r;
                dmem_wdata_s = 64'd0;
                if (clr_idx_r == D_LAST) begin
                    clr_idx_s = {D_IDX{1'b0}};
                    state_s   = ST_LOAD;
                end else begin
                    clr_idx_s = clr_idx_r + D_ONE;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    if ((byte_cnt_r == 2'd3) || ld_last) begin
                        imem_we_s    = 1'b1;
                        imem_wdata_s = assembled_s;
                        byte_cnt_s   = 2'd0;
                        partial_s    = 24'd0;
                        if (ld_last || (word_idx_r == I_LAST)) begin
                            word_idx_s = {I_IDX{1'b0}};
                            state_s    = ST_RUN;
                        end else begin
                            word_idx_s = word_idx_r + I_ONE;
                        end
                    end else begin
                        byte_cnt_s = byte_cnt_r + 2'd1;
                        partial_s  = assembled_s[23:0];
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                dmem_we_s    = d_mem_we;
                dmem_widx_s  = d_mem_addr[d_addr_bits-1:3];
                dmem_wdata_s = d_mem_data;
                if (ld_start) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_CLEAR;
            end
        endcase
    end

    // Control state, loader counters and registered handshake/reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_CLEAR;
            clr_idx_r    <= {D_IDX{1'b0}};
            word_idx_r   <= {I_IDX{1'b0}};
            byte_cnt_r   <= 2'd0;
            partial_r    <= 24'd0;
            ld_ready_r   <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            clr_idx_r    <= clr_idx_s;
            word_idx_r   <= word_idx_s;
            byte_cnt_r   <= byte_cnt_s;
            partial_r    <= partial_s;
            ld_ready_r   <= (state_s == ST_LOAD);
            // Core leaves reset only after a full cycle in RUN and drops on the reload edge.
            core_rst_n_r <= (state_r == ST_RUN) && (state_s == ST_RUN);
        end
    end

    // Memory arrays are not reset, so a reload keeps words it does not overwrite.
    always_ff @(posedge clk) begin
        if (imem_we_s) begin
            imem_r[word_idx_r] <= imem_wdata_s;
        end
        if (dmem_we_s) begin
            dmem_r[dmem_widx_s] <= dmem_wdata_s;
        end
    end

endmodule

// File: tb/tb_polirv_mem_responder.sv
// Self-checking bench for polirv_mem_responder: a behavioural model tracks
// memory contents and mode, a negedge process compares every cycle, and
// directed scenarios add literal expectations.
module tb_polirv_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  i_mem_addr;
    logic [31:0] i_mem_data;
    logic        d_mem_we;
    logic [5:0]  d_mem_addr;
    wire  [63:0] d_mem_data;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_byte;
    logic        ld_ready, core_rst_n;
    logic        bus_en;
    logic [63:0] bus_drv;

    assign d_mem_data = bus_en ? bus_drv : {64{1'bz}};

    always #5 clk = ~clk;

    polirv_mem_responder #(.i_addr_bits(6), .d_addr_bits(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .core_rst_n(core_rst_n)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 = zeroing data memory, 1 = accepting program bytes, 2 = core running
    int          m_mode = 0;
    int          m_clear_left = 8;
    int          m_word = 0;
    int          m_old;
    logic [7:0]  m_pend [$];
    logic [31:0] m_w;
    logic [31:0] imem_m [16];
    bit          imem_known [16];
    logic [63:0] dmem_m [8];
    bit          m_core = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) imem_known[i] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_clear_left = 8; m_word = 0; m_pend.delete(); m_core = 1'b0;
        end else begin
            m_old = m_mode;
            if (m_mode == 0) begin
                dmem_m[8 - m_clear_left] = 64'd0;
                m_clear_left--;
                if (m_clear_left == 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (ld_valid) begin
                    m_pend.push_back(ld_byte);
                    if (m_pend.size() == 4 || ld_last) begin
                        m_w = 32'd0;
                        for (int i = 0; i < m_pend.size(); i++) m_w[8*i +: 8] = m_pend[i];
                        imem_m[m_word] = m_w;
                        imem_known[m_word] = 1'b1;
                        m_pend.delete();
                        if (ld_last || m_word == 15) begin
                            m_mode = 2; m_word = 0;
                        end else begin
                            m_word++;
                        end
                    end
                end
            end else begin
                if (d_mem_we) dmem_m[d_mem_addr[5:3]] = d_mem_data;
                if (ld_start) begin
                    m_mode = 0; m_clear_left = 8;
                end
            end
            m_core = (m_old == 2) && (m_mode == 2);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ld_ready", {63'd0, ld_ready}, {63'd0, m_mode == 1});
            chk("core_rst_n", {63'd0, core_rst_n}, {63'd0, m_core});
            if (imem_known[i_mem_addr[5:2]])
                chk("i_mem_data", {32'd0, i_mem_data}, {32'd0, imem_m[i_mem_addr[5:2]]});
            if (m_mode == 2 && !d_mem_we)
                chk("d_mem_read", d_mem_data, dmem_m[d_mem_addr[5:3]]);
            if (m_mode == 2 && d_mem_we)
                chk("d_mem_release", d_mem_data, bus_drv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        d_mem_we = 1'b0; bus_en = 1'b0;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        do begin
            step(); n++;
        end while (!ld_ready && n < 100);
    endtask

    task automatic send(input logic [7:0] b, input bit last, input bit noise);
        int t = 0;
        while (!ld_ready && t < 50) begin step(); t++; end
        chk("send_ready", {63'd0, ld_ready}, 64'd1);
        if (noise && $urandom_range(0, 2) == 0) begin
            ld_valid = 1'b0; ld_last = 1'($urandom_range(0, 1));
            ld_byte = 8'($urandom); i_mem_addr = 6'($urandom);
            step();
        end
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        if (noise) begin
            d_mem_we = 1'($urandom_range(0, 1)); bus_en = d_mem_we;
            bus_drv = {$urandom, $urandom}; d_mem_addr = 6'($urandom);
            ld_start = ($urandom_range(0, 3) == 0); i_mem_addr = 6'($urandom);
        end
        step();
        idle();
    endtask

    task automatic reload();
        int n;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("reload_core_low", {63'd0, core_rst_n}, 64'd0);
        chk("reload_not_ready", {63'd0, ld_ready}, 64'd0);
        wait_load(n);
        chk("reload_clear_cycles", 64'(n), 64'd8);
    endtask

    task automatic run_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            d_mem_we = 1'($urandom_range(0, 1)); bus_en = d_mem_we;
            bus_drv = {$urandom, $urandom}; d_mem_addr = 6'($urandom);
            i_mem_addr = 6'($urandom); ld_valid = 1'($urandom_range(0, 1));
            ld_byte = 8'($urandom); ld_last = 1'($urandom_range(0, 1));
            step();
        end
        idle();
    endtask

    task automatic read_imem(input int idx, output logic [31:0] v);
        i_mem_addr = {4'(idx), 2'($urandom)};
        #1 v = i_mem_data;
    endtask

    task automatic dmem_all_zero(input string name);
        d_mem_we = 1'b0; bus_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d_mem_addr = {3'(i), 3'($urandom)};
            #1 chk(name, d_mem_data, 64'd0);
        end
    endtask

    // ---------------- directed + random scenario ----------------
    logic [7:0]  prog1 [8];
    logic [7:0]  stream [64];
    logic [31:0] v;
    int          n;

    initial begin
        idle();
        i_mem_addr = 6'd0; d_mem_addr = 6'd0; ld_byte = 8'd0; bus_drv = 64'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_core_low", {63'd0, core_rst_n}, 64'd0);
        chk("rst_not_ready", {63'd0, ld_ready}, 64'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        // Eight clear cycles, then the loader opens
        wait_load(n);
        chk("clear_cycles", 64'(n), 64'd8);
        chk("load_core_low", {63'd0, core_rst_n}, 64'd0);

        // Two-instruction program
        prog1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        for (int i = 0; i < 8; i++) send(prog1[i], i == 7, 1'b0);
        chk("run_entry_not_ready", {63'd0, ld_ready}, 64'd0);
        chk("run_entry_core_low", {63'd0, core_rst_n}, 64'd0);
        step();
        chk("run_core_high", {63'd0, core_rst_n}, 64'd1);
        read_imem(0, v); chk("prog1_w0", {32'd0, v}, 64'h00100013);
        read_imem(1, v); chk("prog1_w1", {32'd0, v}, 64'h00200093);
        dmem_all_zero("dmem_zero_first");

        // Core write then read-back, and release of the bus while writing
        d_mem_we = 1'b1; bus_en = 1'b1; d_mem_addr = 6'h08; bus_drv = 64'hDEADBEEF_CAFEF00D;
        step();
        d_mem_we = 1'b0; bus_en = 1'b0; d_mem_addr = 6'h0F;
        #1 chk("wr_readback", d_mem_data, 64'hDEADBEEF_CAFEF00D);
        d_mem_we = 1'b1; bus_en = 1'b1; bus_drv = 64'h0123_4567_89AB_CDEF;
        #1 chk("we_bus_released", d_mem_data, 64'h0123_4567_89AB_CDEF);
        step();
        idle();
        run_traffic(200);

        // Odd-length program with bus/start noise during the load
        reload();
        for (int i = 1; i <= 5; i++) send(8'(i), i == 5, 1'b1);
        step();
        read_imem(0, v); chk("prog2_w0", {32'd0, v}, 64'h04030201);
        read_imem(1, v); chk("prog2_w1", {32'd0, v}, 64'h00000005);
        dmem_all_zero("dmem_zero_reload");
        run_traffic(100);

        // Fill every instruction word without a last marker
        reload();
        for (int i = 0; i < 64; i++) stream[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) send(stream[i], 1'b0, 1'b1);
        chk("full_not_ready", {63'd0, ld_ready}, 64'd0);
        ld_valid = 1'b1; ld_byte = 8'hEE;
        step();
        chk("byte65_not_ready", {63'd0, ld_ready}, 64'd0);
        step();
        idle();
        for (int i = 0; i < 16; i++) begin
            read_imem(i, v);
            chk("full_word", {32'd0, v},
                {32'd0, stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
        end
        run_traffic(50);

        // Reset in the middle of a word discards the partial bytes
        reload();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #3 chk("midload_rst_core", {63'd0, core_rst_n}, 64'd0);
        chk("midload_rst_ready", {63'd0, ld_ready}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_load(n);
        chk("rst_clear_cycles", 64'(n), 64'd8);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        step();
        read_imem(0, v); chk("rst_reload_w0", {32'd0, v}, 64'h00332211);
        read_imem(1, v);
        chk("rst_reload_w1_kept", {32'd0, v}, {32'd0, stream[7], stream[6], stream[5], stream[4]});
        run_traffic(50);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
